// File: rtl/alu_control.sv
// Registered MIPS ALU control decoder: {ALUOp, funct} -> 4-bit ALU select plus illegal-encoding flag.
// Optional macro ALU_CTL_EXT_FUNCT_EN adds addu/subu/xor/sltu to the R-type decode.
module alu_control #(
    parameter logic [3:0] ILLEGAL_CTL = 4'b1111,
    parameter logic [3:0] RESET_CTL   = 4'b0010
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic [1:0] alu_op,
    input  logic [5:0] func_code,
    output logic [3:0] alu_ctl,
    output logic       illegal
);

    // Returns {illegal, alu_ctl}; every unsupported combination lands in a default branch.
    function automatic logic [4:0] decode(input logic [1:0] op, input logic [5:0] fc);
        logic [4:0] res;
        res = {1'b1, ILLEGAL_CTL};
        case (op)
            2'b00: res = {1'b0, 4'b0010};
            2'b01: res = {1'b0, 4'b0110};
            2'b10: begin
                case (fc)
                    6'h20:   res = {1'b0, 4'b0010};
                    6'h22:   res = {1'b0, 4'b0110};
                    6'h24:   res = {1'b0, 4'b0000};
                    6'h25:   res = {1'b0, 4'b0001};
                    6'h27:   res = {1'b0, 4'b1100};
                    6'h2A:   res = {1'b0, 4'b0111};
`ifdef ALU_CTL_EXT_FUNCT_EN
                    6'h21:   res = {1'b0, 4'b0010};
                    6'h23:   res = {1'b0, 4'b0110};
                    6'h26:   res = {1'b0, 4'b1101};
                    6'h2B:   res = {1'b0, 4'b1000};
`endif
                    default: res = {1'b1, ILLEGAL_CTL};
                endcase
            end
            default: res = {1'b1, ILLEGAL_CTL};
        endcase
        return res;
    endfunction

    logic [4:0] w_dec;
    logic [3:0] r_ctl;
    logic       r_ill;

    assign w_dec = decode(alu_op, func_code);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctl <= RESET_CTL;
            r_ill <= 1'b0;
        end else if (ce) begin
            r_ctl <= w_dec[3:0];
            r_ill <= w_dec[4];
        end
    end

    assign alu_ctl = r_ctl;
    assign illegal = r_ill;

endmodule

// File: tb/tb_alu_control.sv
// Self-checking bench for alu_control: table-driven reference model, per-cycle compare, directed literal checks.
module tb_alu_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ce = 1'b1;
    logic [1:0] alu_op = 2'b10;
    logic [5:0] func_code = 6'h24;
    logic [3:0] alu_ctl;
    logic       illegal;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    bit done = 1'b0;

    alu_control dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .alu_op    (alu_op),
        .func_code (func_code),
        .alu_ctl   (alu_ctl),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Supported R-type functions and the ALU select each one maps to.
    localparam logic [5:0] BASE_FC  [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    localparam logic [3:0] BASE_CTL [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};
    localparam logic [5:0] EXT_FC   [4] = '{6'h21, 6'h23, 6'h26, 6'h2B};
    localparam logic [3:0] EXT_CTL  [4] = '{4'b0010, 4'b0110, 4'b1101, 4'b1000};
    localparam logic [5:0] PICK_FC  [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                                             6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

    function automatic void ref_decode(input logic [1:0] op, input logic [5:0] fc,
                                       output logic [3:0] ctl, output logic ill);
        ctl = 4'b1111;
        ill = 1'b1;
        if (op == 2'd0) begin
            ctl = 4'b0010; ill = 1'b0;
        end else if (op == 2'd1) begin
            ctl = 4'b0110; ill = 1'b0;
        end else if (op == 2'd2) begin
            for (int i = 0; i < 6; i++)
                if (BASE_FC[i] == fc) begin ctl = BASE_CTL[i]; ill = 1'b0; end
`ifdef ALU_CTL_EXT_FUNCT_EN
            for (int i = 0; i < 4; i++)
                if (EXT_FC[i] == fc) begin ctl = EXT_CTL[i]; ill = 1'b0; end
`endif
        end
    endfunction

    // Expected registered outputs: reset value while rst_n low, otherwise last enabled decode.
    logic [3:0] exp_ctl = 4'b0010;
    logic       exp_ill = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        logic [3:0] c;
        logic       l;
        if (!rst_n) begin
            exp_ctl <= 4'b0010;
            exp_ill <= 1'b0;
        end else if (ce) begin
            ref_decode(alu_op, func_code, c, l);
            exp_ctl <= c;
            exp_ill <= l;
        end
    end

    task automatic check(input string name, input logic [3:0] a_ctl, input logic a_ill,
                         input logic [3:0] e_ctl, input logic e_ill);
        n_cmp++;
        if (a_ctl !== e_ctl || a_ill !== e_ill) begin
            n_bad++;
            $display("FAIL %s at %0t: got alu_ctl=%b illegal=%b, want alu_ctl=%b illegal=%b",
                     name, $time, a_ctl, a_ill, e_ctl, e_ill);
        end
    endtask

    task automatic apply(input logic [1:0] op, input logic [5:0] fc, input logic c);
        alu_op    = op;
        func_code = fc;
        ce        = c;
        @(posedge clk);
        #1;
    endtask

    task automatic stimulus();
        logic [3:0] sweep_ctl [6];
        logic [3:0] rc;
        logic       rl;
        sweep_ctl = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};

        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", alu_ctl, illegal, 4'b0010, 1'b0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release_and", alu_ctl, illegal, 4'b0000, 1'b0);

        apply(2'b00, 6'h00, 1'b1); check("lw_sw_add", alu_ctl, illegal, 4'b0010, 1'b0);
        apply(2'b01, 6'h00, 1'b1); check("beq_sub", alu_ctl, illegal, 4'b0110, 1'b0);
        apply(2'b01, 6'h3F, 1'b1); check("beq_func_ignored", alu_ctl, illegal, 4'b0110, 1'b0);

        for (int i = 0; i < 6; i++) begin
            apply(2'b10, BASE_FC[i], 1'b1);
            check("rtype_sweep", alu_ctl, illegal, sweep_ctl[i], 1'b0);
        end

        apply(2'b10, 6'h00, 1'b1); check("rtype_illegal", alu_ctl, illegal, 4'b1111, 1'b1);
        apply(2'b11, 6'h20, 1'b1); check("aluop_reserved", alu_ctl, illegal, 4'b1111, 1'b1);

        apply(2'b00, 6'h00, 1'b1); check("ce_load_add", alu_ctl, illegal, 4'b0010, 1'b0);
        apply(2'b01, 6'h00, 1'b0); check("ce_hold_1", alu_ctl, illegal, 4'b0010, 1'b0);
        apply(2'b11, 6'h00, 1'b0); check("ce_hold_2", alu_ctl, illegal, 4'b0010, 1'b0);
        apply(2'b01, 6'h00, 1'b1); check("ce_resume_sub", alu_ctl, illegal, 4'b0110, 1'b0);

`ifdef ALU_CTL_EXT_FUNCT_EN
        apply(2'b10, 6'h26, 1'b1); check("ext_xor", alu_ctl, illegal, 4'b1101, 1'b0);
        apply(2'b10, 6'h2B, 1'b1); check("ext_sltu", alu_ctl, illegal, 4'b1000, 1'b0);
`else
        apply(2'b10, 6'h26, 1'b1); check("noext_xor", alu_ctl, illegal, 4'b1111, 1'b1);
        apply(2'b10, 6'h2B, 1'b1); check("noext_sltu", alu_ctl, illegal, 4'b1111, 1'b1);
`endif

        // Asynchronous reset in the middle of a cycle, with ce held high.
        apply(2'b10, 6'h25, 1'b1); check("pre_async_or", alu_ctl, illegal, 4'b0001, 1'b0);
        apply(2'b10, 6'h00, 1'b1); check("pre_async_illegal", alu_ctl, illegal, 4'b1111, 1'b1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_now", alu_ctl, illegal, 4'b0010, 1'b0);
        @(posedge clk);
        #1 check("async_reset_overrides_ce", alu_ctl, illegal, 4'b0010, 1'b0);
        rst_n = 1'b1;
        apply(2'b10, 6'h27, 1'b1); check("post_reset_nor", alu_ctl, illegal, 4'b1100, 1'b0);

        // Model sanity: pin a few reference-model results to hand values.
        ref_decode(2'b10, 6'h2A, rc, rl); check("model_slt", rc, rl, 4'b0111, 1'b0);
        ref_decode(2'b11, 6'h24, rc, rl); check("model_reserved", rc, rl, 4'b1111, 1'b1);

        for (int i = 0; i < 500; i++) begin
            logic [1:0] op;
            logic [5:0] fc;
            op = 2'($urandom_range(0, 3));
            fc = ($urandom_range(0, 1) == 0) ? PICK_FC[$urandom_range(0, 9)] : 6'($urandom);
            rst_n = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
            apply(op, fc, ($urandom_range(0, 3) != 0));
        end
        rst_n = 1'b1;
        apply(2'b00, 6'h00, 1'b1);
        @(negedge clk);
        done = 1'b1;
    endtask

    task automatic compare_loop();
        while (!done) begin
            @(negedge clk);
            if (chk_en) check("model_cycle", alu_ctl, illegal, exp_ctl, exp_ill);
        end
    endtask

    initial begin
        fork
            stimulus();
            compare_loop();
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, want completion");
        $fatal(1);
    end

endmodule
